tick_timer_sched: RTL
=====================

Name: tick_timer_sched

Overview:
- Schedules NCH independent millisecond countdown timers on the shared 1 kHz tick.
- A single shared decrementer serves all channels. It is time-multiplexed over NCH consecutive cycles after each tick: one scan.
- Sits between the 1 kHz tick generator and control FSMs that need ms delays (debounce, display hold, timeouts).

Parameters:
- NCH, 4, number of timer channels (2..16).
- DW, 16, counter width in ms; max delay 2^DW-1.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  1-cycle strobe from the 1 kHz tick generator.
- start  in  NCH  per-channel load/start strobe.
- stop  in  NCH  per-channel cancel strobe.
- delay_ms  in  NCH*DW  per-channel delay. Channel i uses bits [i*DW +: DW]; sampled only when start[i]=1.
- busy  out  NCH  channel i is armed and counting.
- done  out  NCH  1-cycle pulse when channel i expires.
- scanning  out  1  scheduler is in the SCAN state.
- overrun  out  1  sticky flag: a tick was lost.

Behaviour:
- Reset (async assert) clears the following; all outputs are 0 during and after reset:
  - all counters, busy, done, overrun;
  - state=IDLE, idx=0, tick_pend=0.
- Storage: cnt[i] (DW bits) and active[i]. busy = active (registered).
- State machine IDLE / SCAN:
  - IDLE: if tick or tick_pend, then next state is SCAN, idx=0, tick_pend=0.
  - SCAN: each cycle processes channel idx.
    - If idx<NCH-1: idx+1.
    - If idx=NCH-1: go to IDLE, or stay in SCAN with idx=0 when tick_pend=1 (clear tick_pend).
  - scanning=1 exactly while state=SCAN. A scan lasts NCH cycles.
- Tick arriving during SCAN:
  - Sets tick_pend.
  - If tick_pend is already 1, the tick is dropped and overrun is set. overrun is cleared only by rst.
  - A tick in the same cycle as the scan's final slot sets tick_pend, so the next scan starts back-to-back.
- Scan slot for channel i (active[i]=1):
  - cnt=1: cnt becomes 0, active becomes 0, done[i]=1 next cycle.
  - otherwise: cnt-1.
  - Inactive channels are untouched. There is no wrap: an active counter never decrements from 0.
- start[i] (any state):
  - cnt[i]=delay, active[i]=1 at the next edge.
  - Start while active: restart with the new delay. No done is produced for the aborted run.
  - delay=0: active stays 0 and done[i] pulses the next cycle.
- stop[i]: active[i]=0 at the next edge, no done. Counter value is don't-care.
- Simultaneous events on the same channel, same cycle, in priority order:
  - stop > start > scan decrement.
  - stop+start gives an idle channel.
  - start during its own scan slot loads delay; the decrement is discarded.
- Tick counting: the first decrement applies to the first tick sampled in or after the start cycle. A tick in the same cycle as start counts.
- Expiry timing:
  - Channel i with delay D expires in the scan triggered by the D-th counted tick.
  - done[i] is high in the cycle after channel i's scan slot. Example: tick at cycle T, no pending, gives done[i] at T+2+i.
- Multiple channels may pulse done in different cycles of one scan, never as a multi-cycle pulse.
- done is a registered pulse, exactly 1 cycle per expiry.

Test Plan:
- Reset mid-scan:
  - Stimulus: arm ch0..3 with 5, assert rst during SCAN at idx=2.
  - Required response: busy=0, done=0, scanning=0, overrun=0 immediately (async); no done after release.
- Basic expiry:
  - Stimulus: start ch1 with delay 3 in the same cycle as a tick, then 2 more ticks.
  - Required response: busy[1]=1 for the run; done[1] pulses once, 3 cycles after the 3rd tick (T+2+1); then busy[1]=0.
- Restart, stop and collisions:
  - Stimulus: ch2 delay 10, restart with 2 after 4 ticks.
    - Required response: done after 2 further ticks.
  - Stimulus: start+stop same cycle on ch0.
    - Required response: busy[0]=0, no done.
  - Stimulus: start ch3 with delay 4 during its own scan slot.
    - Required response: cnt=4, no decrement.
- Zero delay and max delay:
  - Stimulus: start ch0 delay 0.
    - Required response: done[0] the next cycle, busy never 1.
  - Stimulus (DW=4): start ch0 delay 15.
    - Required response: expires on the 15th tick; no wrap.
- Tick pending and overrun (NCH=4):
  - Stimulus: ticks 2 cycles apart.
    - Required response: the second scan runs back-to-back (scanning high 8 cycles), overrun=0.
  - Stimulus: a third tick before the pending scan begins.
    - Required response: overrun=1 and stays 1 until rst.
- Concurrent channels:
  - Stimulus: ch0..3 all delay 1, one tick at T.
  - Required response: done[0..3] pulse at T+2, T+3, T+4, T+5 respectively.

Source files
------------

// File: rtl/tick_timer_sched.sv
// NCH independent millisecond countdown timers sharing one decrementer that is
// time-multiplexed over NCH cycles (one scan) after every 1 kHz tick.
module tick_timer_sched #(
    parameter int NCH = 4,
    parameter int DW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    stop,
    input  logic [NCH*DW-1:0] delay_ms,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done,
    output logic              scanning,
    output logic              overrun
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          tick_pend_reg, tick_pend_next;
    logic          overrun_reg, overrun_next;
    logic [NCH-1:0] ahead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            tick_pend_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            tick_pend_reg <= tick_pend_next;
            overrun_reg   <= overrun_next;
        end
    end

    // A tick landing on the final slot chains straight into the next scan
    // instead of detouring through IDLE, so scans stay back-to-back.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        tick_pend_next = tick_pend_reg;
        overrun_next   = overrun_reg;
        case (state_reg)
            IDLE: begin
                if (tick || tick_pend_reg) begin
                    state_next     = SCAN;
                    idx_next       = '0;
                    tick_pend_next = 1'b0;
                end
            end
            SCAN: begin
                if (tick) begin
                    if (tick_pend_reg) begin
                        overrun_next = 1'b1;
                    end else begin
                        tick_pend_next = 1'b1;
                    end
                end
                if (idx_reg == LAST) begin
                    idx_next = '0;
                    if (tick_pend_reg || tick) begin
                        state_next     = SCAN;
                        tick_pend_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Channels whose slot in the scan now running has not been served yet.
    // Such a scan belongs to a tick older than any start issued now.
    always_comb begin
        ahead = '0;
        if (state_reg == SCAN) begin
            for (int k = 0; k < NCH; k++) begin
                ahead[k] = (k > int'(idx_reg));
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [DW-1:0] cnt_reg, cnt_next;
        logic          active_reg, active_next;
        logic          skip_reg, skip_next;
        logic          done_reg, done_next;
        logic [DW-1:0] dly;
        logic          slot;

        assign dly  = delay_ms[gi*DW +: DW];
        assign slot = (state_reg == SCAN) && (idx_reg == IW'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg    <= '0;
                active_reg <= 1'b0;
                skip_reg   <= 1'b0;
                done_reg   <= 1'b0;
            end else begin
                cnt_reg    <= cnt_next;
                active_reg <= active_next;
                skip_reg   <= skip_next;
                done_reg   <= done_next;
            end
        end

        // Priority: stop, then start, then the scan-slot decrement.
        always_comb begin
            cnt_next    = cnt_reg;
            active_next = active_reg;
            skip_next   = skip_reg;
            done_next   = 1'b0;
            if (stop[gi]) begin
                active_next = 1'b0;
                skip_next   = 1'b0;
            end else if (start[gi]) begin
                cnt_next    = dly;
                active_next = (dly != '0);
                done_next   = (dly == '0);
                skip_next   = (dly != '0) && ahead[gi];
            end else if (slot && active_reg) begin
                skip_next = 1'b0;
                if (!skip_reg) begin
                    if (cnt_reg == DW'(1)) begin
                        cnt_next    = '0;
                        active_next = 1'b0;
                        done_next   = 1'b1;
                    end else if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - DW'(1);
                    end
                end
            end
        end

        assign busy[gi] = active_reg;
        assign done[gi] = done_reg;
    end

    assign scanning = (state_reg == SCAN);
    assign overrun  = overrun_reg;

endmodule
